multi_cycle_control: RTL and testbench

MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

---
 rtl/multi_cycle_control_pkg.sv | 49 ++++
 rtl/mem_wait_timer.sv | 28 ++
 rtl/multi_cycle_control.sv | 172 +++++++++++++++++
 tb/tb_multi_cycle_control.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_cycle_control_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: FSM states, opcodes
// and the datapath mux/ALU select codes.
package multi_cycle_control_pkg;

    typedef enum logic [2:0] {
        S_IF,
        S_ID,
        S_EX,
        S_EX_BR,
        S_MEM,
        S_WB,
        S_HALT,
        S_ERR
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;

    localparam logic [1:0] SRCA_RS1  = 2'b00;
    localparam logic [1:0] SRCA_PC   = 2'b01;
    localparam logic [1:0] SRCA_ZERO = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MDR = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    // Opcodes that take the generic execute state after decode.
    function automatic logic usesEx(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) || (op == OP_STORE) ||
               (op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JALR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive stalled memory cycles; expired fires on the stalled cycle
// that completes TIMEOUT waits. A ready in that cycle suppresses expiry.
module mem_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic ready,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CW-1:0] waitCnt;

    always_ff @(posedge clk) begin
        if (reset || !active || ready || (TIMEOUT == 0)) begin
            waitCnt <= '0;
        end else if (waitCnt != LAST) begin
            waitCnt <= waitCnt + CW'(1);
        end
    end

    assign expired = (TIMEOUT > 0) && active && !ready && (waitCnt == LAST);

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle RV32I control unit: Moore FSM driving datapath strobes and mux
// selects, with a memory wait timeout and a retired-instruction counter.
module multi_cycle_control
    import multi_cycle_control_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             ecall_halt,
    input  logic             bcond,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic             pc_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       wb_sel,
    output logic             is_halted,
    output logic             err,
    output logic [CNT_W-1:0] retired
);

    state_t state;
    state_t nextState;
    logic   waitActive;
    logic   expired;

    assign waitActive = !reset && ((state == S_IF) || (state == S_MEM));

    mem_wait_timer #(.TIMEOUT(TIMEOUT)) uWaitTimer (
        .clk     (clk),
        .reset   (reset),
        .active  (waitActive),
        .ready   (mem_ready),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IF;
            retired <= '0;
        end else begin
            state <= nextState;
            if (pc_write) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

    always_comb begin
        nextState = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        iord      = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        pc_src    = 1'b0;
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALU_ADD;
        wb_sel    = WB_ALU;

        unique case (state)
            S_IF: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    nextState = S_ID;
                end else if (expired) begin
                    nextState = S_ERR;
                end
            end
            S_ID: begin
                // ALUOut <= PC + imm, the branch/jump target for later states
                alu_src_a = SRCA_PC;
                alu_src_b = SRCB_IMM;
                if (usesEx(opcode)) begin
                    nextState = S_EX;
                end else if (opcode == OP_BRANCH) begin
                    nextState = S_EX_BR;
                end else if (opcode == OP_JAL) begin
                    nextState = S_WB;
                end else if (opcode == OP_SYSTEM) begin
                    if (ecall_halt) begin
                        nextState = S_HALT;
                    end else begin
                        pc_write  = 1'b1;
                        nextState = S_IF;
                    end
                end else begin
                    nextState = S_ERR;
                end
            end
            S_EX: begin
                if (opcode == OP_AUIPC) begin
                    alu_src_a = SRCA_PC;
                end else if (opcode == OP_LUI) begin
                    alu_src_a = SRCA_ZERO;
                end
                alu_src_b = (opcode == OP_R) ? SRCB_RS2 : SRCB_IMM;
                alu_op    = ((opcode == OP_R) || (opcode == OP_I)) ? ALU_FUNCT : ALU_ADD;
                nextState = ((opcode == OP_LOAD) || (opcode == OP_STORE)) ? S_MEM : S_WB;
            end
            S_EX_BR: begin
                alu_op    = ALU_BRANCH;
                pc_write  = 1'b1;
                pc_src    = bcond;
                nextState = S_IF;
            end
            S_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = (opcode == OP_STORE);
                if (mem_ready) begin
                    if (opcode == OP_STORE) begin
                        pc_write  = 1'b1;
                        nextState = S_IF;
                    end else begin
                        nextState = S_WB;
                    end
                end else if (expired) begin
                    nextState = S_ERR;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                if (opcode == OP_LOAD) begin
                    wb_sel = WB_MDR;
                end else if ((opcode == OP_JAL) || (opcode == OP_JALR)) begin
                    wb_sel = WB_PC4;
                    pc_src = 1'b1;
                end
                nextState = S_IF;
            end
            S_HALT, S_ERR: begin
                nextState = state;
            end
            default: begin
                nextState = S_ERR;
            end
        endcase

        // Reset silences every strobe in the cycle it is asserted.
        if (reset) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            iord      = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
            pc_src    = 1'b0;
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_RS2;
            alu_op    = ALU_ADD;
            wb_sel    = WB_ALU;
        end
    end

    assign is_halted = !reset && (state == S_HALT);
    assign err       = !reset && (state == S_ERR);

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control with TIMEOUT=4 and CNT_W=4, checking
// the full output vector every cycle against hand-derived values.
module tb_multi_cycle_control;

    localparam logic [6:0] R_OP   = 7'b0110011;
    localparam logic [6:0] I_OP   = 7'b0010011;
    localparam logic [6:0] LD_OP  = 7'b0000011;
    localparam logic [6:0] ST_OP  = 7'b0100011;
    localparam logic [6:0] BR_OP  = 7'b1100011;
    localparam logic [6:0] JAL_OP = 7'b1101111;
    localparam logic [6:0] LUI_OP = 7'b0110111;
    localparam logic [6:0] AUI_OP = 7'b0010111;
    localparam logic [6:0] SYS_OP = 7'b1110011;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic       ecall_halt;
    logic       bcond;
    logic       mem_ready;
    logic       mem_req, mem_we, iord, ir_write, pc_write, reg_write, pc_src;
    logic [1:0] alu_src_a, alu_src_b, alu_op, wb_sel;
    logic       is_halted, err;
    logic [3:0] retired;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    multi_cycle_control #(.TIMEOUT(4), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .ecall_halt (ecall_halt),
        .bcond      (bcond),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .wb_sel     (wb_sel),
        .is_halted  (is_halted),
        .err        (err),
        .retired    (retired)
    );

    // {mem_req, mem_we, iord, ir_write, pc_write, reg_write, pc_src,
    //  alu_src_a, alu_src_b, alu_op, wb_sel, is_halted, err}
    logic [16:0] obs;
    assign obs = {mem_req, mem_we, iord, ir_write, pc_write, reg_write, pc_src,
                  alu_src_a, alu_src_b, alu_op, wb_sel, is_halted, err};

    function automatic logic [16:0] ov(input logic mr, input logic we, input logic io,
                                       input logic irw, input logic pcw, input logic rw,
                                       input logic pcs, input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] op, input logic [1:0] wb,
                                       input logic h, input logic e);
        return {mr, we, io, irw, pcw, rw, pcs, a, b, op, wb, h, e};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic rdy, input logic [16:0] exp);
        mem_ready = rdy;
        #1;
        check(tag, 32'(obs), 32'(exp));
        tick();
    endtask

    logic [16:0] eIfRdy, eIfWait, eId, eIdEcall, eExR, eExI, eExMem, eExAui, eExLui;
    logic [16:0] eBrT, eBrF, eMemLd, eMemSt, eMemStRdy, eWbAlu, eWbLd, eWbJ, eHalt, eErr;

    task automatic runAdd(input string tag);
        opcode = R_OP;
        step({tag, " IF"}, 1'b1, eIfRdy);
        step({tag, " ID"}, 1'b1, eId);
        step({tag, " EX"}, 1'b1, eExR);
        step({tag, " WB"}, 1'b1, eWbAlu);
    endtask

    task automatic doReset();
        reset     = 1'b1;
        mem_ready = 1'b1;
        #1;
        check("reset outputs", 32'(obs), 32'(0));
        tick();
        check("reset retired", 32'(retired), 32'(0));
        reset = 1'b0;
    endtask

    initial begin
        eIfRdy    = ov(1,0,0,1,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0,0);
        eIfWait   = ov(1,0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0,0);
        eId       = ov(0,0,0,0,0,0,0, 2'd1,2'd1,2'd0,2'd0, 0,0);
        eIdEcall  = ov(0,0,0,0,1,0,0, 2'd1,2'd1,2'd0,2'd0, 0,0);
        eExR      = ov(0,0,0,0,0,0,0, 2'd0,2'd0,2'd2,2'd0, 0,0);
        eExI      = ov(0,0,0,0,0,0,0, 2'd0,2'd1,2'd2,2'd0, 0,0);
        eExMem    = ov(0,0,0,0,0,0,0, 2'd0,2'd1,2'd0,2'd0, 0,0);
        eExAui    = ov(0,0,0,0,0,0,0, 2'd1,2'd1,2'd0,2'd0, 0,0);
        eExLui    = ov(0,0,0,0,0,0,0, 2'd2,2'd1,2'd0,2'd0, 0,0);
        eBrT      = ov(0,0,0,0,1,0,1, 2'd0,2'd0,2'd1,2'd0, 0,0);
        eBrF      = ov(0,0,0,0,1,0,0, 2'd0,2'd0,2'd1,2'd0, 0,0);
        eMemLd    = ov(1,0,1,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0,0);
        eMemSt    = ov(1,1,1,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0,0);
        eMemStRdy = ov(1,1,1,0,1,0,0, 2'd0,2'd0,2'd0,2'd0, 0,0);
        eWbAlu    = ov(0,0,0,0,1,1,0, 2'd0,2'd0,2'd0,2'd0, 0,0);
        eWbLd     = ov(0,0,0,0,1,1,0, 2'd0,2'd0,2'd0,2'd1, 0,0);
        eWbJ      = ov(0,0,0,0,1,1,1, 2'd0,2'd0,2'd0,2'd2, 0,0);
        eHalt     = ov(0,0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 1,0);
        eErr      = ov(0,0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0,1);

        opcode     = R_OP;
        ecall_halt = 1'b0;
        bcond      = 1'b0;
        doReset();

        // ADD with single-cycle memory
        runAdd("add");
        check("add retired", 32'(retired), 32'(1));

        // LOAD with three stalled MEM cycles
        opcode = LD_OP;
        step("ld IF", 1'b1, eIfRdy);
        step("ld ID", 1'b1, eId);
        step("ld EX", 1'b1, eExMem);
        for (int i = 0; i < 3; i++) step("ld MEM wait", 1'b0, eMemLd);
        step("ld MEM rdy", 1'b1, eMemLd);
        step("ld WB", 1'b1, eWbLd);
        check("ld retired", 32'(retired), 32'(2));

        // Branch taken then not taken
        opcode = BR_OP;
        bcond  = 1'b1;
        step("brT IF", 1'b1, eIfRdy);
        step("brT ID", 1'b1, eId);
        step("brT EX_BR", 1'b1, eBrT);
        bcond = 1'b0;
        step("brF IF", 1'b1, eIfRdy);
        step("brF ID", 1'b1, eId);
        step("brF EX_BR", 1'b1, eBrF);
        check("br retired", 32'(retired), 32'(4));

        // ECALL without halt
        opcode = SYS_OP;
        step("ecall IF", 1'b1, eIfRdy);
        step("ecall ID", 1'b1, eIdEcall);
        check("ecall retired", 32'(retired), 32'(5));

        // STORE
        opcode = ST_OP;
        step("st IF", 1'b1, eIfRdy);
        step("st ID", 1'b1, eId);
        step("st EX", 1'b1, eExMem);
        step("st MEM wait", 1'b0, eMemSt);
        step("st MEM rdy", 1'b1, eMemStRdy);
        check("st retired", 32'(retired), 32'(6));

        // JAL skips execute
        opcode = JAL_OP;
        step("jal IF", 1'b1, eIfRdy);
        step("jal ID", 1'b1, eId);
        step("jal WB", 1'b1, eWbJ);

        opcode = AUI_OP;
        step("auipc IF", 1'b1, eIfRdy);
        step("auipc ID", 1'b1, eId);
        step("auipc EX", 1'b1, eExAui);
        step("auipc WB", 1'b1, eWbAlu);

        opcode = LUI_OP;
        step("lui IF", 1'b1, eIfRdy);
        step("lui ID", 1'b1, eId);
        step("lui EX", 1'b1, eExLui);
        step("lui WB", 1'b1, eWbAlu);

        opcode = I_OP;
        step("addi IF", 1'b1, eIfRdy);
        step("addi ID", 1'b1, eId);
        step("addi EX", 1'b1, eExI);
        step("addi WB", 1'b1, eWbAlu);
        check("mix retired", 32'(retired), 32'(10));

        // Ready arriving on the fourth wait cycle beats the timeout
        opcode = R_OP;
        for (int i = 0; i < 3; i++) step("late IF wait", 1'b0, eIfWait);
        step("late IF rdy", 1'b1, eIfRdy);
        step("late ID", 1'b1, eId);
        step("late EX", 1'b1, eExR);
        step("late WB", 1'b1, eWbAlu);
        check("late retired", 32'(retired), 32'(11));

        // Fetch never completes: ERR after four waits
        for (int i = 0; i < 4; i++) step("to IF wait", 1'b0, eIfWait);
        step("to ERR", 1'b1, eErr);
        step("to ERR sticky", 1'b1, eErr);
        check("to retired", 32'(retired), 32'(11));
        doReset();

        // ECALL halt is absorbing and does not retire
        runAdd("pre-halt");
        opcode     = SYS_OP;
        ecall_halt = 1'b1;
        step("halt IF", 1'b1, eIfRdy);
        step("halt ID", 1'b1, eId);
        step("halt HALT", 1'b1, eHalt);
        step("halt sticky", 1'b0, eHalt);
        check("halt retired", 32'(retired), 32'(1));
        ecall_halt = 1'b0;
        doReset();

        // Four-bit retired counter wraps after sixteen instructions
        for (int i = 0; i < 15; i++) runAdd("wrap add");
        check("wrap retired 15", 32'(retired), 32'(15));
        runAdd("wrap add16");
        check("wrap retired 0", 32'(retired), 32'(0));
        runAdd("wrap add17");
        check("wrap retired 1", 32'(retired), 32'(1));

        // Reset asserted while a load stalls in MEM
        opcode = LD_OP;
        step("rm IF", 1'b1, eIfRdy);
        step("rm ID", 1'b1, eId);
        step("rm EX", 1'b1, eExMem);
        step("rm MEM wait", 1'b0, eMemLd);
        reset     = 1'b1;
        mem_ready = 1'b0;
        #1;
        check("rm reset outputs", 32'(obs), 32'(0));
        tick();
        reset = 1'b0;
        #1;
        check("rm after IF", 32'(obs), 32'(eIfWait));
        check("rm retired", 32'(retired), 32'(0));

        $display("%0d/%0d checks passed", nChecks - nFails, nChecks);
        $finish;
    end

endmodule
